// File: rtl/seven_seg_reader.sv
// Seven-segment pattern reader: debounces strobed active-low segment
// samples, decodes accepted patterns to hex and buffers one event.
module seven_seg_reader #(
    parameter int STABLE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       seg_strobe,
    output logic [3:0] digit_out,
    output logic       blank_out,
    output logic       err_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    localparam logic [3:0] N = 4'(STABLE_CNT);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic       emit;

    logic [3:0] digit_q;
    logic       blank_q, err_q, valid_q, ovf_q;

    logic [3:0] dec_digit;
    logic       dec_blank, dec_err;
    logic       pop, load, drop;

    // Decode the current sample; an emit always carries seg_in itself.
    always_comb begin
        dec_digit = 4'd0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_in)
            7'h40: dec_digit = 4'h0;
            7'h79: dec_digit = 4'h1;
            7'h24: dec_digit = 4'h2;
            7'h30: dec_digit = 4'h3;
            7'h19: dec_digit = 4'h4;
            7'h12: dec_digit = 4'h5;
            7'h02: dec_digit = 4'h6;
            7'h78: dec_digit = 4'h7;
            7'h00: dec_digit = 4'h8;
            7'h10: dec_digit = 4'h9;
            7'h08: dec_digit = 4'hA;
            7'h03: dec_digit = 4'hB;
            7'h46: dec_digit = 4'hC;
            7'h21: dec_digit = 4'hD;
            7'h06: dec_digit = 4'hE;
            7'h0E: dec_digit = 4'hF;
            7'h7F: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    // Stability tracker: next state, candidate, count and emit strobe.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        if (seg_strobe) begin
            if (state_q == S_TRACK && seg_in == cand_q) begin
                if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
                if ((cnt_q + 4'd1) == N) begin
                    emit    = 1'b1;
                    state_d = S_LOCKED;
                end
            end else if (state_q == S_LOCKED && seg_in == cand_q) begin
                state_d = S_LOCKED;
            end else begin
                cand_d = seg_in;
                cnt_d  = 4'd1;
                if (N == 4'd1) begin
                    emit    = 1'b1;
                    state_d = S_LOCKED;
                end else begin
                    state_d = S_TRACK;
                end
            end
        end
    end

    assign pop  = valid_q & out_ready;
    assign load = emit & (~valid_q | pop);
    assign drop = emit & valid_q & ~pop;

    // Tracker state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_WAIT;
            cand_q  <= 7'h7F;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-entry output buffer with sticky drop flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_q <= 4'd0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (load) begin
                digit_q <= dec_digit;
                blank_q <= dec_blank;
                err_q   <= dec_err;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign digit_out = digit_q;
    assign blank_out = blank_q;
    assign err_out   = err_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: run-length reference model feeding a
// scoreboard queue, checked by an independent output monitor.
module tb_seven_seg_reader;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       seg_strobe;
    logic [3:0] digit_out;
    logic       blank_out, err_out, out_valid, out_ready, overflow;

    seven_seg_reader #(.STABLE_CNT(N)) dut (
        .clock(clock), .reset(reset),
        .seg_in(seg_in), .seg_strobe(seg_strobe),
        .digit_out(digit_out), .blank_out(blank_out), .err_out(err_out),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       err;
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  failures = 0;
    logic [6:0] legal [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model state
    logic [6:0] run_val;
    int         run_len;
    bit         full_next, ovf_next;
    bit         valid_now, ovf_now;
    bit         mon_on;
    int         n_events;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t ref_decode(input logic [6:0] p);
        ev_t e;
        e = '0;
        if (p == 7'h7F) begin
            e.blank = 1'b1;
            return e;
        end
        for (int i = 0; i < 16; i++)
            if (legal[i] == p) begin
                e.digit = 4'(i);
                return e;
            end
        e.err = 1'b1;
        return e;
    endfunction

    // One clock cycle of stimulus, plus the model's view of the edge ending it.
    task automatic cyc(input bit stb, input logic [6:0] p, input bit rdy);
        bit emit, pop;
        @(posedge clock);
        #1;
        reset = 1'b0;
        seg_strobe = stb;
        seg_in = p;
        out_ready = rdy;
        valid_now = full_next;
        ovf_now = ovf_next;
        emit = 0;
        if (stb) begin
            if (run_len > 0 && p == run_val) begin
                run_len++;
                emit = (run_len == N);
            end else begin
                run_val = p;
                run_len = 1;
                emit = (N == 1);
            end
        end
        pop = full_next && rdy;
        if (emit) begin
            if (!full_next || pop) begin
                expq.push_back(ref_decode(p));
                full_next = 1;
                n_events++;
            end else begin
                ovf_next = 1;
            end
        end else if (pop) begin
            full_next = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        seg_strobe = 1'b1;
        out_ready = 1'b0;
        valid_now = full_next;
        ovf_now = ovf_next;
        full_next = 0;
        ovf_next = 0;
        run_len = 0;
        @(negedge clock);
        expq.delete();
    endtask

    task automatic check_zero(input string tag);
        @(negedge clock);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_digit"}, digit_out, 0);
        chk({tag, "_blank"}, blank_out, 0);
        chk({tag, "_err"}, err_out, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    task automatic stab(input logic [6:0] p, input bit rdy);
        for (int i = 0; i < N; i++) cyc(1, p, rdy);
        cyc(0, 7'h7F, rdy);
    endtask

    // Monitor: checks flags every cycle and pops the scoreboard on a handshake.
    always @(negedge clock) begin
        if (mon_on && !reset) begin
            chk("valid", out_valid, valid_now);
            chk("overflow", overflow, ovf_now);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    ev_t e;
                    e = expq.pop_front();
                    chk("digit", digit_out, e.digit);
                    chk("blank", blank_out, e.blank);
                    chk("err", err_out, e.err);
                end
            end
        end
    end

    initial begin
        int ev0;
        logic [6:0] p;
        reset = 1'b1;
        seg_in = 7'h7F;
        seg_strobe = 1'b0;
        out_ready = 1'b0;
        run_val = 7'h7F;
        run_len = 0;
        full_next = 0;
        ovf_next = 0;
        valid_now = 0;
        ovf_now = 0;
        mon_on = 0;
        n_events = 0;
        repeat (3) @(posedge clock);
        do_reset();
        check_zero("reset");
        mon_on = 1;

        // four strobes of 3, then a fifth: exactly one event
        ev0 = n_events;
        stab(7'h30, 1);
        cyc(1, 7'h30, 1);
        cyc(0, 7'h7F, 1);
        chk("one_event_3", n_events - ev0, 1);

        // interrupted run of 5, then 1
        ev0 = n_events;
        foreach (legal[i]) if (i == 5) p = legal[i];
        cyc(1, p, 1); cyc(1, p, 1); cyc(1, p, 1);
        stab(7'h79, 1);
        chk("one_event_1", n_events - ev0, 1);

        // overflow with consumer stalled
        stab(7'h40, 0);
        stab(7'h0E, 0);
        cyc(0, 7'h7F, 0);
        @(negedge clock);
        chk("held_digit", digit_out, 0);
        chk("sticky_ovf", overflow, 1);
        cyc(0, 7'h7F, 1);
        cyc(0, 7'h7F, 1);

        // blank and illegal patterns
        stab(7'h7F, 1);
        stab(7'h7E, 1);

        // emit coinciding with a pop
        do_reset();
        check_zero("reset2");
        for (int i = 0; i < N; i++) cyc(1, 7'h24, 0);
        for (int i = 0; i < N - 1; i++) cyc(1, 7'h19, 0);
        cyc(1, 7'h19, 1);
        cyc(0, 7'h7F, 1);
        cyc(0, 7'h7F, 1);

        // reset mid-track with a pending event
        stab(7'h02, 0);
        for (int i = 0; i < N - 1; i++) cyc(1, 7'h78, 0);
        do_reset();
        check_zero("reset3");
        ev0 = n_events;
        cyc(1, 7'h78, 1);
        cyc(0, 7'h7F, 1);
        cyc(0, 7'h7F, 1);
        chk("no_event_after_reset", n_events - ev0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) p = legal[$urandom_range(0, 15)];
            else if (r < 8) p = 7'h7F;
            else p = 7'($urandom);
            if ($urandom_range(0, 3) == 0) p = run_val;
            cyc($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 400) == 0) do_reset();
        end

        // drain
        for (int i = 0; i < 5; i++) cyc(0, 7'h7F, 1);
        @(negedge clock);
        chk("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
